// File: rtl/countdown16_pkg.sv
// countdown16 shared definitions.
// Default width and run-state encoding used by the RTL and the bench.
package countdown16_pkg;

  localparam int DEF_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/countdown16_if.sv
// countdown16 control/status bundle.
// The master drives load/start/pause/reload_en; the counter reports count/busy/done.
interface countdown16_if
  import countdown16_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) ();

  logic             load;
  logic [WIDTH-1:0] load_value;
  logic             start;
  logic             pause;
  logic             reload_en;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;

  modport master (
    output load,
    output load_value,
    output start,
    output pause,
    output reload_en,
    input  count,
    input  busy,
    input  done
  );

  modport slave (
    input  load,
    input  load_value,
    input  start,
    input  pause,
    input  reload_en,
    output count,
    output busy,
    output done
  );

endinterface

// File: rtl/countdown16_dec16.sv
// dec16: WIDTH-bit decrementer, companion of the incrementer.
// Adds all-ones and drops the carry, so out = in - 1 mod 2^WIDTH.
module dec16
  import countdown16_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out
);

  logic [WIDTH-1:0] w_ones;

  assign w_ones = {WIDTH{1'b1}};
  assign out    = in + w_ones;

endmodule

// File: rtl/countdown16.sv
// countdown16: loadable down-counter with start, pause and auto-reload.
// Pulses done for one cycle when the count reaches zero or reloads.
module countdown16
  import countdown16_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic         clk,
  input  logic         reset,
  countdown16_if.slave bus
);

  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_reload;
  logic [WIDTH-1:0] w_count_nxt;
  logic [WIDTH-1:0] w_reload_nxt;
  logic [WIDTH-1:0] w_dec;
  logic             r_done;
  logic             r_busy;
  logic             w_done_nxt;
  logic             w_reload_ok;

  dec16 #(
    .WIDTH(WIDTH)
  ) u_dec (
    .in (r_count),
    .out(w_dec)
  );

  // A zero reload value would wrap to all-ones, so treat it as no reload.
  assign w_reload_ok = bus.reload_en && (r_reload != ZERO);

  always_comb begin
    w_state_nxt  = r_state;
    w_count_nxt  = r_count;
    w_reload_nxt = r_reload;
    w_done_nxt   = 1'b0;
    if (bus.load) begin
      w_count_nxt  = bus.load_value;
      w_reload_nxt = bus.load_value;
      w_state_nxt  = IDLE;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (bus.start && (r_count != ZERO))
            w_state_nxt = RUN;
        end
        RUN: begin
          if (bus.pause) begin
            w_state_nxt = HOLD;
          end else if (r_count == ZERO) begin
            w_state_nxt = IDLE;
          end else if (r_count == ONE) begin
            w_done_nxt = 1'b1;
            if (w_reload_ok) begin
              w_count_nxt = r_reload;
            end else begin
              w_count_nxt = ZERO;
              w_state_nxt = IDLE;
            end
          end else begin
            w_count_nxt = w_dec;
          end
        end
        HOLD: begin
          if (!bus.pause)
            w_state_nxt = RUN;
        end
        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_count  <= ZERO;
      r_reload <= ZERO;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_count  <= w_count_nxt;
      r_reload <= w_reload_nxt;
      r_done   <= w_done_nxt;
      r_busy   <= (w_state_nxt != IDLE);
    end
  end

  assign bus.count = r_count;
  assign bus.busy  = r_busy;
  assign bus.done  = r_done;

endmodule

// File: tb/tb_countdown16.sv
// Self-checking bench for countdown16.
// Directed scenarios plus random traffic against a behavioural model.
module tb_countdown16;
  import countdown16_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;

  countdown16_if #(.WIDTH(DEF_WIDTH)) bus ();

  countdown16 #(
    .WIDTH(DEF_WIDTH)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Model: active = counting or paused, hold = paused.
  logic [15:0] m_count;
  logic [15:0] m_reload;
  bit          m_active;
  bit          m_hold;
  bit          m_done;

  task automatic model_edge(input bit rs, input bit ld,
                            input logic [15:0] lv, input bit st,
                            input bit pa, input bit re);
    if (rs) begin
      m_count = 0; m_reload = 0;
      m_active = 0; m_hold = 0; m_done = 0;
    end else if (ld) begin
      m_count = lv; m_reload = lv;
      m_active = 0; m_hold = 0; m_done = 0;
    end else begin
      m_done = 0;
      if (!m_active) begin
        if (st && m_count != 0) m_active = 1;
      end else if (m_hold) begin
        if (!pa) m_hold = 0;
      end else if (pa) begin
        m_hold = 1;
      end else if (m_count == 1) begin
        m_done = 1;
        if (re && m_reload != 0) m_count = m_reload;
        else begin
          m_count = 0;
          m_active = 0;
        end
      end else begin
        m_count = m_count - 16'd1;
      end
    end
  endtask

  task automatic cyc(input bit rs, input bit ld, input logic [15:0] lv,
                     input bit st, input bit pa, input bit re);
    @(negedge clk);
    reset = rs;
    bus.load = ld;
    bus.load_value = lv;
    bus.start = st;
    bus.pause = pa;
    bus.reload_en = re;
    @(posedge clk);
    model_edge(rs, ld, lv, st, pa, re);
    #1;
  endtask

  task automatic test_reset();
    cyc(1, 0, 16'h0, 0, 0, 0);
    cyc(1, 0, 16'h0, 0, 0, 0);
    n_chk++;
    if (bus.count !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_count got %h want 0000", bus.count);
    end
    n_chk++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags got busy=%b done=%b want 0 0",
               bus.busy, bus.done);
    end
  endtask

  task automatic test_basic();
    cyc(0, 1, 16'd5, 0, 0, 0);
    cyc(0, 0, 16'd0, 1, 0, 0);
    n_chk++;
    if (bus.count !== 16'd5 || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_start got count=%0d busy=%b want 5 1",
               bus.count, bus.busy);
    end
    for (int i = 1; i <= 6; i++) begin
      logic [15:0] e_cnt;
      bit e_done, e_busy;
      cyc(0, 0, 16'd0, 0, 0, 0);
      e_cnt  = (i >= 5) ? 16'd0 : 16'(5 - i);
      e_done = (i == 5);
      e_busy = (i < 5);
      n_chk++;
      if (bus.count !== e_cnt || bus.done !== e_done ||
          bus.busy !== e_busy) begin
        n_fail++;
        $display("FAIL basic_edge%0d got c=%0d d=%b b=%b want %0d %b %b",
                 i, bus.count, bus.done, bus.busy, e_cnt, e_done, e_busy);
      end
    end
  endtask

  task automatic test_zero_start();
    bit seen;
    seen = 0;
    cyc(0, 1, 16'd0, 0, 0, 0);
    cyc(0, 0, 16'd0, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 16'd0, 1, 0, 1);
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) seen = 1;
    end
    n_chk++;
    if (seen || bus.count !== 16'd0) begin
      n_fail++;
      $display("FAIL zero_start got c=%0d busy=%b done=%b want 0 0 0",
               bus.count, bus.busy, bus.done);
    end
  endtask

  task automatic test_reload();
    cyc(0, 1, 16'd3, 0, 0, 1);
    cyc(0, 0, 16'd0, 1, 0, 1);
    n_chk++;
    if (bus.count !== 16'd3) begin
      n_fail++;
      $display("FAIL reload_start got %0d want 3", bus.count);
    end
    for (int i = 1; i <= 10; i++) begin
      logic [15:0] e_cnt;
      bit e_done;
      cyc(0, 0, 16'd0, 0, 0, 1);
      e_done = (i % 3 == 0);
      e_cnt  = e_done ? 16'd3 : 16'(3 - (i % 3));
      n_chk++;
      if (bus.count !== e_cnt || bus.done !== e_done ||
          bus.busy !== 1'b1) begin
        n_fail++;
        $display("FAIL reload_edge%0d got c=%0d d=%b b=%b want %0d %b 1",
                 i, bus.count, bus.done, bus.busy, e_cnt, e_done);
      end
    end
  endtask

  task automatic test_pause();
    int k;
    bit got;
    got = 0;
    cyc(0, 1, 16'hFFFF, 0, 0, 0);
    cyc(0, 0, 16'h0, 1, 0, 0);
    cyc(0, 0, 16'h0, 0, 0, 0);
    cyc(0, 0, 16'h0, 0, 0, 0);
    // Three pause edges plus the resume edge freeze the count for 4 cycles.
    for (int i = 3; i <= 6; i++) begin
      cyc(0, 0, 16'h0, 0, (i <= 5), 0);
      n_chk++;
      if (bus.count !== 16'hFFFD || bus.busy !== 1'b1) begin
        n_fail++;
        $display("FAIL pause_hold%0d got %h busy=%b want FFFD 1",
                 i, bus.count, bus.busy);
      end
    end
    cyc(0, 0, 16'h0, 0, 0, 0);
    n_chk++;
    if (bus.count !== 16'hFFFC) begin
      n_fail++;
      $display("FAIL pause_resume got %h want FFFC", bus.count);
    end
    k = 7;
    while (k < 70000 && !got) begin
      cyc(0, 0, 16'h0, 0, 0, 0);
      k++;
      if (bus.done === 1'b1) got = 1;
    end
    n_chk++;
    if (!got || k != 65535 + 4) begin
      n_fail++;
      $display("FAIL pause_done_edge got %0d (seen=%b) want %0d",
               k, got, 65535 + 4);
    end
  endtask

  task automatic test_load_abort();
    int k;
    cyc(0, 1, 16'd8, 0, 0, 0);
    cyc(0, 0, 16'd0, 1, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 16'd0, 0, 0, 0);
    cyc(0, 1, 16'd2, 1, 0, 0);
    n_chk++;
    if (bus.count !== 16'd2 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL load_abort got c=%0d b=%b d=%b want 2 0 0",
               bus.count, bus.busy, bus.done);
    end
    cyc(0, 0, 16'd0, 1, 0, 0);
    k = 0;
    while (k < 10 && bus.done !== 1'b1) begin
      cyc(0, 0, 16'd0, 0, 0, 0);
      k++;
    end
    n_chk++;
    if (k != 2 || bus.count !== 16'd0) begin
      n_fail++;
      $display("FAIL load_restart got edge=%0d c=%0d want 2 0",
               k, bus.count);
    end
  endtask

  task automatic test_reset_terminal();
    cyc(0, 1, 16'd4, 0, 0, 1);
    cyc(0, 0, 16'd0, 1, 0, 1);
    for (int i = 0; i < 3; i++) cyc(0, 0, 16'd0, 0, 0, 1);
    n_chk++;
    if (bus.count !== 16'd1) begin
      n_fail++;
      $display("FAIL rst_term_pre got %0d want 1", bus.count);
    end
    cyc(1, 0, 16'd0, 0, 0, 1);
    n_chk++;
    if (bus.count !== 16'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_term got c=%0d b=%b d=%b want 0 0 0",
               bus.count, bus.busy, bus.done);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 2000; i++) begin
      bit ld, st, pa, re, rs;
      logic [15:0] lv;
      rs = ($urandom_range(0, 199) == 0);
      ld = ($urandom_range(0, 19) == 0);
      lv = 16'($urandom_range(0, 6));
      pa = ($urandom_range(0, 5) == 0);
      st = ($urandom_range(0, 3) == 0) && !pa;
      re = $urandom_range(0, 1);
      cyc(rs, ld, lv, st, pa, re);
      n_chk++;
      if (bus.count !== m_count || bus.busy !== m_active ||
          bus.done !== m_done) begin
        n_fail++;
        $display("FAIL rand%0d got c=%0d b=%b d=%b want %0d %b %b",
                 i, bus.count, bus.busy, bus.done,
                 m_count, m_active, m_done);
      end
    end
  endtask

  initial begin
    bus.load = 0;
    bus.load_value = 0;
    bus.start = 0;
    bus.pause = 0;
    bus.reload_en = 0;
    test_reset();
    test_basic();
    test_zero_start();
    test_reload();
    test_pause();
    test_load_abort();
    test_reset_terminal();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
